// File: rtl/trig_cond_pkg.sv
// Shared definitions for the trigger conditioner: FSM encoding and default widths.
package trig_cond_pkg;

    localparam int DEF_FILTER_W  = 8;
    localparam int DEF_HOLDOFF_W = 16;
    localparam int DEF_STRETCH   = 4;
    localparam int DEF_MISSED_W  = 16;
    localparam int TRIG_COUNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_FIRE    = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_DONE    = 3'd4
    } trig_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trig_glitch_filter.sv
// Synchronises the raw trigger pin, applies polarity, rejects short glitches
// and produces the filtered level plus a one-cycle rising-edge event.
module trig_glitch_filter
    import trig_cond_pkg::*;
#(
    parameter int FILTER_W = DEF_FILTER_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raw,
    input  logic                polarity,
    input  logic [FILTER_W-1:0] filter_len,
    output logic                level,
    output logic                edge_evt
);

    logic                s1_q;
    logic                s2_q;
    logic                lvl;
    logic                filt_q;
    logic                filt_d_q;
    logic [FILTER_W-1:0] cnt_q;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so s2_q takes the previous s1_q, giving two real flop stages.
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Polarity select: a falling pin becomes a rising level when polarity is 1.
    assign lvl = s2_q ^ polarity;

    // Glitch filter: the level must differ for filter_len+1 consecutive cycles to be adopted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= 1'b0;
            filt_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            filt_d_q <= filt_q;
            if (lvl == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= filter_len) begin
                // >= rather than == so a live shrink of filter_len cannot let the count wrap.
                filt_q <= lvl;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level    = filt_q;
    assign edge_evt = filt_q & ~filt_d_q;

endmodule

// File: rtl/trig_conditioner.sv
// Trigger conditioner: filtered edge -> fixed-width pulse, with holdoff,
// single-shot arming and accepted/missed statistics.
module trig_conditioner
    import trig_cond_pkg::*;
#(
    parameter int FILTER_W  = DEF_FILTER_W,
    parameter int HOLDOFF_W = DEF_HOLDOFF_W,
    parameter int STRETCH   = DEF_STRETCH,
    parameter int MISSED_W  = DEF_MISSED_W
) (
    input  logic                    i_TrigInClk_p,
    input  logic                    i_TrigInResetn_p,
    input  logic                    i_TrigRaw_p,
    input  logic                    i_Enable_p,
    input  logic                    i_Polarity_p,
    input  logic [FILTER_W-1:0]     i_FilterLen_p,
    input  logic [HOLDOFF_W-1:0]    i_Holdoff_p,
    input  logic                    i_SingleShot_p,
    input  logic                    i_Rearm_p,
    input  logic                    i_CntClr_p,
    output logic                    o_TrigOut_p,
    output logic                    o_Armed_p,
    output logic [TRIG_COUNT_W-1:0] o_TrigCount_p,
    output logic [MISSED_W-1:0]     o_Missed_p
);

    localparam int                     STRETCH_CW   = cnt_width(STRETCH);
    localparam logic [STRETCH_CW-1:0]  STRETCH_LAST = STRETCH_CW'(STRETCH - 1);
    localparam logic [HOLDOFF_W-1:0]   HOLD_LAST    = HOLDOFF_W'(1);

    trig_state_e               state_q, state_d;
    logic [STRETCH_CW-1:0]     stretch_q, stretch_d;
    logic [HOLDOFF_W-1:0]      hold_q, hold_d;
    logic                      single_q, single_d;
    logic                      trig_out_q;
    logic                      armed_q;
    logic [TRIG_COUNT_W-1:0]   trig_count_q;
    logic [MISSED_W-1:0]       missed_q;
    logic                      edge_evt;
    logic                      unused_filt_level;
    logic                      accept;
    logic                      missed_evt;

    trig_glitch_filter #(
        .FILTER_W (FILTER_W)
    ) u_filter (
        .clk        (i_TrigInClk_p),
        .rst_n      (i_TrigInResetn_p),
        .raw        (i_TrigRaw_p),
        .polarity   (i_Polarity_p),
        .filter_len (i_FilterLen_p),
        .level      (unused_filt_level),
        .edge_evt   (edge_evt)
    );

    // Next-state logic: arming, pulse stretching, holdoff and single-shot handling.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        stretch_d  = stretch_q;
        hold_d     = hold_q;
        single_d   = single_q;
        accept     = 1'b0;
        missed_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Enable_p) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (edge_evt) begin
                    state_d   = ST_FIRE;
                    stretch_d = '0;
                    accept    = 1'b1;
                end
            end
            ST_FIRE: begin
                missed_evt = edge_evt;
                if (stretch_q == STRETCH_LAST) begin
                    // Mode and holdoff are captured here so later changes do not disturb this cycle.
                    single_d = i_SingleShot_p;
                    if (i_Holdoff_p != '0) begin
                        state_d = ST_HOLDOFF;
                        hold_d  = i_Holdoff_p;
                    end else begin
                        state_d = i_SingleShot_p ? ST_DONE : ST_ARMED;
                    end
                end else begin
                    stretch_d = stretch_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                missed_evt = edge_evt;
                if (hold_q == HOLD_LAST) state_d = single_q ? ST_DONE : ST_ARMED;
                else                     hold_d  = hold_q - 1'b1;
            end
            ST_DONE: begin
                missed_evt = edge_evt;
                if (i_Rearm_p) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
        // Disable overrides everything, truncating any pulse in progress.
        if (!i_Enable_p) begin
            state_d = ST_IDLE;
            accept  = 1'b0;
        end
    end

    // State, sequencing counters and registered outputs.
    always_ff @(posedge i_TrigInClk_p or negedge i_TrigInResetn_p) begin
        if (!i_TrigInResetn_p) begin
            state_q    <= ST_IDLE;
            stretch_q  <= '0;
            hold_q     <= '0;
            single_q   <= 1'b0;
            trig_out_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stretch_q  <= stretch_d;
            hold_q     <= hold_d;
            single_q   <= single_d;
            trig_out_q <= (state_d == ST_FIRE);
            armed_q    <= (state_d == ST_ARMED);
        end
    end

    // Statistics: wrapping accept count, saturating missed count; clear has priority.
    always_ff @(posedge i_TrigInClk_p or negedge i_TrigInResetn_p) begin
        if (!i_TrigInResetn_p) begin
            trig_count_q <= '0;
            missed_q     <= '0;
        end else if (i_CntClr_p) begin
            trig_count_q <= '0;
            missed_q     <= '0;
        end else begin
            if (accept)                         trig_count_q <= trig_count_q + 1'b1;
            if (missed_evt && (missed_q != '1)) missed_q     <= missed_q + 1'b1;
        end
    end

    assign o_TrigOut_p   = trig_out_q;
    assign o_Armed_p     = armed_q;
    assign o_TrigCount_p = trig_count_q;
    assign o_Missed_p    = missed_q;

endmodule

// File: tb/tb_trig_conditioner.sv
// Scenario bench for trig_conditioner: expected pulses are queued when the raw
// stimulus is driven and compared by a monitor when the DUT emits each pulse.
module tb_trig_conditioner;
    import trig_cond_pkg::*;

    localparam int STRETCH = 4;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        raw;
    logic        enable;
    logic        polarity;
    logic [7:0]  filter_len;
    logic [15:0] holdoff;
    logic        single_shot;
    logic        rearm;
    logic        cnt_clr;
    logic        trig_out;
    logic        armed;
    logic [31:0] trig_count;
    logic [15:0] missed;

    int     cyc    = 0;
    int     errors = 0;
    int     checks = 0;
    pulse_t exp_q[$];

    trig_conditioner #(
        .FILTER_W  (8),
        .HOLDOFF_W (16),
        .STRETCH   (STRETCH),
        .MISSED_W  (16)
    ) dut (
        .i_TrigInClk_p    (clk),
        .i_TrigInResetn_p (rst_n),
        .i_TrigRaw_p      (raw),
        .i_Enable_p       (enable),
        .i_Polarity_p     (polarity),
        .i_FilterLen_p    (filter_len),
        .i_Holdoff_p      (holdoff),
        .i_SingleShot_p   (single_shot),
        .i_Rearm_p        (rearm),
        .i_CntClr_p       (cnt_clr),
        .o_TrigOut_p      (trig_out),
        .o_Armed_p        (armed),
        .o_TrigCount_p    (trig_count),
        .o_Missed_p       (missed)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number m, cyc == m.
    always @(posedge clk) cyc++;

    // Pulse monitor: measures each output pulse and compares it with the oldest expectation.
    logic   prev_out = 1'b0;
    int     cur_start = 0;
    int     cur_width = 0;
    pulse_t exp_p;
    always @(negedge clk) begin
        if (trig_out === 1'b1 && !prev_out) begin
            cur_start = cyc;
            cur_width = 1;
        end else if (trig_out === 1'b1) begin
            cur_width++;
        end else if (prev_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: start=%0d width=%0d, required no pulse", cur_start, cur_width);
            end else begin
                exp_p = exp_q.pop_front();
                if (exp_p.start !== cur_start || exp_p.width !== cur_width) begin
                    errors++;
                    $display("FAIL pulse_shape: start=%0d width=%0d, required start=%0d width=%0d",
                             cur_start, cur_width, exp_p.start, exp_p.width);
                end
            end
        end
        prev_out = (trig_out === 1'b1);
    end

    // Global time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive raw to lvl for len sampled cycles, then back; k is the first sampling edge.
    task automatic raw_pulse(input logic lvl, input int len, output int k);
        @(negedge clk);
        k   = cyc + 1;
        raw = lvl;
        repeat (len) @(negedge clk);
        raw = ~lvl;
    endtask

    task automatic clear_counts();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        wait_cycles(3);
        checks++; if (trig_out !== 1'b0)      begin errors++; $display("FAIL reset_trig_out: got %b, required 0", trig_out); end
        checks++; if (armed !== 1'b0)         begin errors++; $display("FAIL reset_armed: got %b, required 0", armed); end
        checks++; if (trig_count !== 32'd0)   begin errors++; $display("FAIL reset_count: got %0d, required 0", trig_count); end
        checks++; if (missed !== 16'd0)       begin errors++; $display("FAIL reset_missed: got %0d, required 0", missed); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required IDLE", dut.state_q); end
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_cycles(3);
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL armed_after_enable: got %b, required 1", armed); end
    endtask

    task automatic test_basic();
        int k;
        filter_len = 8'd2;
        clear_counts();
        raw_pulse(1'b1, 10, k);
        exp_q.push_back('{start: k + 5, width: STRETCH});
        wait_cycles(25);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_pending: got %0d pulses outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d, required 1", trig_count); end
        checks++; if (missed !== 16'd0)     begin errors++; $display("FAIL basic_missed: got %0d, required 0", missed); end
    endtask

    task automatic test_glitch();
        int k;
        filter_len = 8'd3;
        clear_counts();
        raw_pulse(1'b1, 3, k);
        wait_cycles(20);
        checks++; if (trig_count !== 32'd0) begin errors++; $display("FAIL glitch_count: got %0d, required 0", trig_count); end
        checks++; if (missed !== 16'd0)     begin errors++; $display("FAIL glitch_missed: got %0d, required 0", missed); end
        // Exactly N+1 cycles is the shortest accepted pulse.
        raw_pulse(1'b1, 4, k);
        exp_q.push_back('{start: k + 6, width: STRETCH});
        wait_cycles(20);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_pending: got %0d pulses outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL glitch_min_count: got %0d, required 1", trig_count); end
    endtask

    task automatic test_holdoff();
        int k1, k2, k3, k4;
        filter_len = 8'd0;
        holdoff    = 16'd20;
        clear_counts();
        raw_pulse(1'b1, 3, k1);
        exp_q.push_back('{start: k1 + 3, width: STRETCH});
        wait_cycles(6);
        raw_pulse(1'b1, 3, k2);
        wait_cycles(30);
        checks++; if (k2 - k1 != 10)        begin errors++; $display("FAIL holdoff_spacing: got %0d, required 10", k2 - k1); end
        checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL holdoff_count1: got %0d, required 1", trig_count); end
        checks++; if (missed !== 16'd1)     begin errors++; $display("FAIL holdoff_missed: got %0d, required 1", missed); end
        raw_pulse(1'b1, 3, k3);
        exp_q.push_back('{start: k3 + 3, width: STRETCH});
        wait_cycles(27);
        raw_pulse(1'b1, 3, k4);
        exp_q.push_back('{start: k4 + 3, width: STRETCH});
        wait_cycles(35);
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL holdoff_pending: got %0d pulses outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (trig_count !== 32'd3) begin errors++; $display("FAIL holdoff_count3: got %0d, required 3", trig_count); end
        checks++; if (missed !== 16'd1)     begin errors++; $display("FAIL holdoff_missed_after: got %0d, required 1", missed); end
        holdoff = 16'd0;
    endtask

    task automatic test_single_shot();
        int k;
        filter_len  = 8'd0;
        single_shot = 1'b1;
        clear_counts();
        raw_pulse(1'b1, 3, k);
        exp_q.push_back('{start: k + 3, width: STRETCH});
        for (int i = 0; i < 2; i++) begin
            wait_cycles(7);
            raw_pulse(1'b1, 3, k);
        end
        wait_cycles(10);
        checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", trig_count); end
        checks++; if (missed !== 16'd2)     begin errors++; $display("FAIL single_missed: got %0d, required 2", missed); end
        checks++; if (armed !== 1'b0)       begin errors++; $display("FAIL single_done_armed: got %b, required 0", armed); end
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        checks++; if (armed !== 1'b1)       begin errors++; $display("FAIL single_rearm: got %b, required 1", armed); end
        raw_pulse(1'b1, 3, k);
        exp_q.push_back('{start: k + 3, width: STRETCH});
        wait_cycles(15);
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL single_pending: got %0d pulses outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (trig_count !== 32'd2) begin errors++; $display("FAIL single_count2: got %0d, required 2", trig_count); end
        single_shot = 1'b0;
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_polarity();
        int k;
        filter_len = 8'd0;
        enable     = 1'b0;
        wait_cycles(2);
        raw = 1'b1;
        wait_cycles(5);
        polarity = 1'b1;
        wait_cycles(5);
        enable = 1'b1;
        wait_cycles(3);
        clear_counts();
        // Falling edge fires; the rising edge at the end of the helper must not.
        raw_pulse(1'b0, 5, k);
        exp_q.push_back('{start: k + 3, width: STRETCH});
        wait_cycles(20);
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL polarity_pending: got %0d pulses outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL polarity_count: got %0d, required 1", trig_count); end
        checks++; if (missed !== 16'd0)     begin errors++; $display("FAIL polarity_missed: got %0d, required 0", missed); end
        enable = 1'b0;
        wait_cycles(2);
        polarity = 1'b0;
        wait_cycles(3);
        raw = 1'b0;
        wait_cycles(5);
        enable = 1'b1;
        wait_cycles(3);
    endtask

    task automatic test_disable_and_clear();
        int k;
        filter_len = 8'd0;
        clear_counts();
        raw_pulse(1'b1, 3, k);
        exp_q.push_back('{start: k + 3, width: 2});
        @(negedge clk);
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL disable_pulse_start: got %b, required 1", trig_out); end
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++; if (trig_out !== 1'b0)       begin errors++; $display("FAIL disable_trig_out: got %b, required 0", trig_out); end
        checks++; if (armed !== 1'b0)          begin errors++; $display("FAIL disable_armed: got %b, required 0", armed); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL disable_state: got %0d, required IDLE", dut.state_q); end
        enable = 1'b1;
        wait_cycles(5);
        checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL disable_count: got %0d, required 1", trig_count); end
        // Clear lands on the same edge as the accept.
        raw_pulse(1'b1, 3, k);
        exp_q.push_back('{start: k + 3, width: STRETCH});
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++; if (trig_count !== 32'd0) begin errors++; $display("FAIL clear_wins_count: got %0d, required 0", trig_count); end
        checks++; if (missed !== 16'd0)     begin errors++; $display("FAIL clear_wins_missed: got %0d, required 0", missed); end
        wait_cycles(10);
        raw_pulse(1'b1, 3, k);
        exp_q.push_back('{start: k + 3, width: STRETCH});
        wait_cycles(10);
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL disable_pending: got %0d pulses outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL count_after_clear: got %0d, required 1", trig_count); end
    endtask

    task automatic test_reset_mid_pulse();
        int k;
        filter_len = 8'd0;
        raw_pulse(1'b1, 3, k);
        exp_q.push_back('{start: k + 3, width: 1});
        @(negedge clk);
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL midreset_pulse_start: got %b, required 1", trig_out); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (trig_out !== 1'b0)    begin errors++; $display("FAIL midreset_trig_out: got %b, required 0", trig_out); end
        checks++; if (trig_count !== 32'd0) begin errors++; $display("FAIL midreset_count: got %0d, required 0", trig_count); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(5);
        checks++; if (armed !== 1'b1)     begin errors++; $display("FAIL midreset_rearmed: got %b, required 1", armed); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_pending: got %0d pulses outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        rst_n       = 1'b0;
        raw         = 1'b0;
        enable      = 1'b0;
        polarity    = 1'b0;
        filter_len  = 8'd0;
        holdoff     = 16'd0;
        single_shot = 1'b0;
        rearm       = 1'b0;
        cnt_clr     = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_holdoff();
        test_single_shot();
        test_polarity();
        test_disable_and_clear();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trig_conditioner.md
Name: trig_conditioner

Overview:
Conditions the raw external trigger line before it enters the trigger/counter stage's input CDC (its i_TrigIn_p / i_TrigInClk_p pair). Synchronises the asynchronous pin, selects polarity, rejects glitches shorter than a programmable length, edge-detects, and emits a fixed-width stretched pulse so the downstream syncer cannot miss it. A holdoff window and a single-shot arm mode suppress retriggering; accepted and missed triggers are counted for software.

Parameters:
FILTER_W, 8, width of the glitch-filter length field.
HOLDOFF_W, 16, width of the holdoff length field.
STRETCH, 4, output pulse width in clocks; minimum 1.
MISSED_W, 16, width of the saturating missed-trigger counter.

Ports:
i_TrigInClk_p  in  1  single clock for the block; also drives the downstream stage's trigger-input clock.
i_TrigInResetn_p  in  1  reset, asynchronous assert, active-low.
i_TrigRaw_p  in  1  raw external trigger pin, asynchronous to the clock.
i_Enable_p  in  1  block enable (level).
i_Polarity_p  in  1  edge select: 0 = rising, 1 = falling.
i_FilterLen_p  in  FILTER_W  glitch-filter length N.
i_Holdoff_p  in  HOLDOFF_W  holdoff cycles H after each pulse.
i_SingleShot_p  in  1  mode: 1 = disarm after one trigger.
i_Rearm_p  in  1  one-cycle pulse; re-arms from DONE.
i_CntClr_p  in  1  synchronous clear of both counters.
o_TrigOut_p  out  1  stretched trigger pulse to the downstream stage.
o_Armed_p  out  1  high while in ARMED.
o_TrigCount_p  out  32  accepted-trigger count; wraps.
o_Missed_p  out  MISSED_W  count of qualified edges rejected outside ARMED; saturates at all-ones.

Behaviour:
- Reset: all flops 0; o_TrigOut_p=0, o_Armed_p=0, both counters 0; FSM in IDLE; filtered level 0.
- Sync: two-flop synchroniser s1→s2, then XOR with i_Polarity_p to give level L.
- Glitch filter: register F holds the filtered level. Counter C resets to 0 whenever L==F. When L!=F, C increments; when L!=F and C==N, F<=L and C<=0.
  - N=0 means F follows L with one clock of delay.
  - A pulse shorter than N+1 consecutive cycles never changes F.
- Event: E = F & ~F_d (rising edge of F), one cycle wide.
- Latency: raw high first sampled at clock edge k → E is high in the cycle after edge k+2+N → o_TrigOut_p rises at edge k+3+N.
- FSM states:
  - IDLE: leave to ARMED when i_Enable_p=1. An E in the same cycle is ignored and not counted.
  - ARMED: on E → FIRE; o_TrigOut_p<=1; o_TrigCount_p++.
  - FIRE: hold o_TrigOut_p=1 for exactly STRETCH cycles. Then go to HOLDOFF if H>0, else DONE if i_SingleShot_p, else ARMED.
  - HOLDOFF: stay exactly H cycles. Then go to DONE if i_SingleShot_p, else ARMED.
  - DONE: i_Rearm_p → ARMED. i_Rearm_p in any other state is ignored.
- Missed edges: E in FIRE, HOLDOFF or DONE increments o_Missed_p (saturating).
- Disable: i_Enable_p=0 in any state → IDLE at the next edge; o_TrigOut_p and o_Armed_p drop at that edge, truncating any pulse in progress. The filter keeps running.
- Config sampling: i_SingleShot_p and i_Holdoff_p are sampled on the FIRE→next transition. i_FilterLen_p is used live; a change takes effect on the next compare.
- i_CntClr_p in the same cycle as an increment: the clear wins, and both counters read 0 on the next cycle.
- Counter wrap: o_TrigCount_p goes 0xFFFFFFFF→0 with no flag.
- Reset mid-pulse: o_TrigOut_p clears asynchronously.

Decomposition:
- Package trig_cond_pkg: FSM state encoding (IDLE, ARMED, FIRE, HOLDOFF, DONE) and default width constants.
- Sub-module trig_glitch_filter: synchroniser, polarity XOR and filter; outputs F and E. The top level holds the FSM, stretch/holdoff counters and statistics.

Test Plan:
- N=2, rising polarity, raw high from edge 0 held for 10 cycles → o_TrigOut_p high from edge 5 for 4 cycles; o_TrigCount_p=1.
- N=3, raw high for 3 cycles → no pulse; o_TrigCount_p=0; o_Missed_p=0.
- H=20, two qualified edges 10 cycles apart → one pulse; o_Missed_p=1. Repeat with edges 30 cycles apart → two pulses.
- i_SingleShot_p=1, three triggers → one pulse; o_Missed_p=2; after i_Rearm_p, next trigger → second pulse.
- i_Polarity_p=1, falling edge on raw → pulse; the rising edge that follows → no pulse.
- i_Enable_p dropped on the 2nd cycle of a pulse → o_TrigOut_p low at the next edge; state IDLE. Also assert i_CntClr_p in the same cycle as an accept → o_TrigCount_p=0.
